// File: rtl/subtractor_serial_if.sv
// Handshake/data bundle for the bit-serial subtractor.
//   start  request from the client; only honoured while the subtractor is idle
//   in0    minuend, captured when start is accepted
//   in1    subtrahend, captured when start is accepted
//   busy   high while an operation is in flight (running or presenting result)
//   done   one-cycle pulse; out is valid from this cycle on
//   out    {borrow, diff}: two's-complement in0 - in1, WIDTH+1 bits
// The master modport is the client side, the slave modport is the subtractor.
interface subtractor_serial_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   out;

  modport master (
    output start, in0, in1,
    input  busy, done, out
  );

  modport slave (
    input  start, in0, in1,
    output busy, done, out
  );
endinterface

// File: rtl/subtractor_serial.sv
// Bit-serial, handshaked subtractor: out = in0 - in1, one bit per clock,
// LSB first, through a single full-subtractor cell and a borrow flop.
// The result is WIDTH+1 bits wide so it always holds the exact signed
// difference of two unsigned WIDTH-bit operands (MSB is the final borrow).
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-high; clears all state and aborts any operation
//   bus    subtractor_serial_if.slave (start/in0/in1 in, busy/done/out out)
// Sequence: IDLE --start--> RUN (WIDTH cycles) --> DONE (1 cycle) --> IDLE.
module subtractor_serial #(
  parameter int WIDTH = 10
) (
  input  logic                clock,
  input  logic                reset,
  subtractor_serial_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [WIDTH:0]   out_q;
  logic [CW-1:0]    cnt;
  logic             bin;

  logic             diff_bit;
  logic             bout;
  logic             last_bit;
  logic             busy_c;
  logic             done_c;

  // One full-subtractor cell working on the current LSBs of the shifting
  // operands and the borrow carried from the previous bit.
  always_comb begin
    diff_bit = a[0] ^ b[0] ^ bin;
    bout     = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & bin);
    last_bit = (cnt == LAST_BIT);
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs. Start is only looked at in IDLE, so a
  // request raised while busy is simply dropped rather than queued.
  always_comb begin
    state_next = state;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_c = 1'b1;
        if (last_bit) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_c     = 1'b1;
        done_c     = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath. Operands are captured once on an accepted start, so later
  // changes on in0/in1 cannot disturb a running operation. Each difference
  // bit enters at the top of the result register, so after WIDTH shifts
  // the first (LSB) difference bit has reached result[0].
  // The visible output is loaded on the final RUN edge, i.e. on entry to
  // DONE, using the freshly computed last bit and borrow; it then holds
  // until the next operation completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a      <= '0;
      b      <= '0;
      result <= '0;
      out_q  <= '0;
      cnt    <= '0;
      bin    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a   <= bus.in0;
            b   <= bus.in1;
            cnt <= '0;
            bin <= 1'b0;
          end
        end
        ST_RUN: begin
          a      <= a >> 1;
          b      <= b >> 1;
          bin    <= bout;
          cnt    <= cnt + 1'b1;
          result <= {diff_bit, result[WIDTH-1:1]};
          if (last_bit) begin
            out_q <= {bout, diff_bit, result[WIDTH-1:1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.out  = out_q;

endmodule

// File: tb/tb_subtractor_serial.sv
// Self-checking bench for subtractor_serial. Expected results come from
// plain integer subtraction of the operands, truncated to WIDTH+1 bits.
module tb_subtractor_serial;

  localparam int WIDTH = 10;
  localparam int LATENCY = WIDTH + 1;
  localparam int PERIOD = WIDTH + 2;
  localparam int MAX_WAIT = 60;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  subtractor_serial_if #(.WIDTH(WIDTH)) bus_if ();

  subtractor_serial #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clock = ~clock;

  // Reference difference: exact in0 - in1 as a WIDTH+1 bit two's-complement value.
  function automatic logic [WIDTH:0] model_diff(input int unsigned x, input int unsigned y);
    int diff;
    diff = int'(x) - int'(y);
    return diff[WIDTH:0];
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Runs one operation starting from IDLE. Operands are scrambled every
  // cycle after capture; with disturb set, a start pulse carrying other
  // operands is also issued mid-run. Checks latency, result and idle hold.
  task automatic apply_stimulus(input int unsigned x, input int unsigned y,
                                input bit disturb, input string tag);
    int n;
    logic [WIDTH:0] expected;
    expected = model_diff(x, y);
    @(negedge clock);
    bus_if.in0   = x[WIDTH-1:0];
    bus_if.in1   = y[WIDTH-1:0];
    bus_if.start = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      bus_if.start = (disturb && n == 4) ? 1'b1 : 1'b0;
      bus_if.in0   = WIDTH'($urandom);
      bus_if.in1   = WIDTH'($urandom);
    end while (!bus_if.done && n < MAX_WAIT);
    bus_if.start = 1'b0;
    check_output({tag, "_latency"}, n, LATENCY);
    check_output({tag, "_out"}, bus_if.out, expected);
    check_output({tag, "_borrow"}, bus_if.out[WIDTH], (x < y) ? 1 : 0);
    @(negedge clock);
    check_output({tag, "_idle_done"}, bus_if.done, 0);
    check_output({tag, "_idle_busy"}, bus_if.busy, 0);
    check_output({tag, "_hold"}, bus_if.out, expected);
  endtask

  initial begin
    int done_seen;
    int last_done;
    int low_run;
    int ops;
    int unsigned x;
    int unsigned y;

    bus_if.start = 1'b0;
    bus_if.in0   = '0;
    bus_if.in1   = '0;

    // Reset state.
    repeat (3) @(negedge clock);
    check_output("reset_busy", bus_if.busy, 0);
    check_output("reset_done", bus_if.done, 0);
    check_output("reset_out", bus_if.out, 0);
    reset = 1'b0;
    @(negedge clock);
    check_output("idle_busy", bus_if.busy, 0);

    // Directed cases and boundaries.
    apply_stimulus(5, 3, 1'b0, "pos_small");
    apply_stimulus(3, 5, 1'b0, "neg_small");
    apply_stimulus(0, 1023, 1'b0, "min_minus_max");
    apply_stimulus(1023, 0, 1'b0, "max_minus_min");
    apply_stimulus(0, 0, 1'b0, "zero_zero");
    apply_stimulus(1023, 1023, 1'b0, "max_max");
    apply_stimulus(512, 511, 1'b0, "near_equal");

    // Start pulse during RUN must be ignored.
    apply_stimulus(700, 123, 1'b1, "disturbed");

    // Randomized operands.
    for (int i = 0; i < 16; i++) begin
      x = $urandom_range(1023, 0);
      y = $urandom_range(1023, 0);
      if (i % 4 == 0) y = x;
      apply_stimulus(x, y, (i % 3 == 0), "random");
    end

    // Start held high: equal operands presented only while idle, garbage
    // otherwise. Expect a done every PERIOD cycles and one idle cycle between.
    @(negedge clock);
    bus_if.start = 1'b1;
    bus_if.in0   = 10'd600;
    bus_if.in1   = 10'd600;
    last_done = -1;
    low_run   = 0;
    ops       = 0;
    for (int c = 1; c <= 5 * PERIOD; c++) begin
      @(negedge clock);
      if (bus_if.done) begin
        ops++;
        check_output("stream_out", bus_if.out, model_diff(600, 600));
        if (last_done >= 0) check_output("stream_period", c - last_done, PERIOD);
        last_done = c;
      end
      if (!bus_if.busy) begin
        low_run++;
      end else begin
        if (low_run != 0) check_output("stream_idle_gap", low_run, 1);
        low_run = 0;
      end
      if (bus_if.busy) begin
        bus_if.in0 = WIDTH'($urandom);
        bus_if.in1 = WIDTH'($urandom);
      end else begin
        bus_if.in0 = 10'd600;
        bus_if.in1 = 10'd600;
      end
    end
    check_output("stream_ops", (ops >= 4) ? 1 : 0, 1);
    bus_if.start = 1'b0;
    repeat (PERIOD + 2) @(negedge clock);

    // Seed a non-zero result so the reset clear is observable.
    apply_stimulus(900, 17, 1'b0, "pre_abort");

    // Asynchronous reset during RUN cycle 5 aborts without a done pulse.
    @(negedge clock);
    bus_if.in0   = 10'd321;
    bus_if.in1   = 10'd45;
    bus_if.start = 1'b1;
    @(negedge clock);
    bus_if.start = 1'b0;
    repeat (4) @(negedge clock);
    check_output("abort_busy_before", bus_if.busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check_output("abort_busy", bus_if.busy, 0);
    check_output("abort_out", bus_if.out, 0);
    check_output("abort_done", bus_if.done, 0);
    @(negedge clock);
    reset = 1'b0;
    done_seen = 0;
    for (int c = 0; c < PERIOD + 4; c++) begin
      @(negedge clock);
      if (bus_if.done) done_seen++;
    end
    check_output("abort_no_done", done_seen, 0);
    check_output("abort_out_held", bus_if.out, 0);
    apply_stimulus(10, 4, 1'b0, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
